regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester A.
REQ-002 Parameter: XLEN, default 32, data width of write data.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: a_req  input  1  requester A (ALU writeback) write request.
REQ-006 Port: a_rd  input  5  requester A destination register index.
REQ-007 Port: a_data  input  XLEN  requester A write data.
REQ-008 Port: a_gnt  output  1  requester A granted this cycle (combinational).
REQ-009 Port: b_req, b_rd, b_data, b_gnt  same directions/widths as A  requester B (load unit writeback).
REQ-010 Port: rf_we  output  1  register-file write enable (registered).
REQ-011 Port: rf_waddr  output  5  register-file write index (registered).
REQ-012 Port: rf_wdata  output  XLEN  register-file write data (registered).
REQ-013 Port: busy  output  1  high when both requests present in same cycle (one requester stalled).

Function
REQ-014 Arbiter SHALL assert at most one of a_gnt/b_gnt in any cycle.
REQ-015 Requester SHALL hold req, rd, data stable until it samples gnt=1; gnt is the handshake completion.
REQ-016 Single requester: gnt asserted same cycle req is high.
REQ-017 Both requesting, FAIR=1: grant requester not granted most recently; FAIR=0: grant A.
REQ-018 Round-robin pointer SHALL be a 1-bit state (LAST_A, LAST_B); transitions only on a grant; after reset LAST_B (A wins first tie).
REQ-019 Granted request SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle after the grant cycle (latency 1).
REQ-020 Grant with rd = 0 SHALL complete the handshake but drive rf_we=0 in the following cycle (x0 never written).
REQ-021 No grant in a cycle: rf_we=0 next cycle; rf_waddr/rf_wdata hold previous values.
REQ-022 Back-to-back grants SHALL sustain one register-file write per cycle with no bubble.
REQ-023 busy SHALL be combinational: a_req & b_req.

Reset
REQ-024 While reset=0: a_gnt=0, b_gnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, pointer=LAST_B, counters=0, asynchronously.
REQ-025 Reset asserted mid-handshake SHALL discard the in-flight write (rf_we=0); requester must re-request after reset release.
REQ-026 First grant possible in first rising edge after reset deasserts.

Configuration
REQ-027 Macro WB_ARB_STALL_CNT_EN: when defined, add outputs a_stall_cnt[15:0] and b_stall_cnt[15:0], each incrementing on every cycle its requester has req=1 and gnt=0, saturating at 16'hFFFF, cleared only by reset.
REQ-028 Without WB_ARB_STALL_CNT_EN: stall-count ports and counters absent; all other behaviour identical.

Verification
REQ-029 Reset then a_req=1, a_rd=1, a_data=32'h12345678 -> a_gnt=1 same cycle; next cycle rf_we=1, rf_waddr=1, rf_wdata=32'h12345678.
REQ-030 a_req and b_req both high (a_rd=2/32'h87654321, b_rd=3/32'hABCDEF01), FAIR=1 -> cycle 1 a_gnt, cycle 2 b_gnt; rf writes reg2 then reg3 in consecutive cycles; busy=1 in cycle 1 only.
REQ-031 Both held high 4 cycles, FAIR=0 -> a_gnt every cycle, b_gnt=0; with WB_ARB_STALL_CNT_EN b_stall_cnt=4.
REQ-032 b_req=1, b_rd=0, b_data=32'hFFFFFFFF -> b_gnt=1; next cycle rf_we=0.
REQ-033 Grant of a_rd=5 then reset=0 before next edge -> rf_we stays 0, no write to reg5; after release, pointer LAST_B.
REQ-034 Stall counter forced past 65535 denied cycles -> b_stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle: ALU (A) and load unit (B) requests in,
// one register-file write port out.
interface regfile_wb_arbiter_if #(
   parameter int XLEN = 32
);
   logic            a_req;
   logic [4:0]      a_rd;
   logic [XLEN-1:0] a_data;
   logic            a_gnt;
   logic            b_req;
   logic [4:0]      b_rd;
   logic [XLEN-1:0] b_data;
   logic            b_gnt;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            busy;

   modport master (
      output a_req, a_rd, a_data,
      output b_req, b_rd, b_data,
      input  a_gnt, b_gnt, busy,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  a_req, a_rd, a_data,
      input  b_req, b_rd, b_data,
      output a_gnt, b_gnt, busy,
      output rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-way writeback arbiter onto a single register-file write port.
// WB_ARB_STALL_CNT_EN adds per-requester saturating stall counters.
module regfile_wb_arbiter #(
   parameter bit FAIR = 1'b1,
   parameter int XLEN = 32
) (
   input  logic clk,
   input  logic reset,
   regfile_wb_arbiter_if.slave wb
`ifdef WB_ARB_STALL_CNT_EN
   ,
   output logic [15:0] a_stall_cnt,
   output logic [15:0] b_stall_cnt
`endif
);

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } ptr_t;

   ptr_t            ptr;
   ptr_t            ptr_nxt;
   logic            a_win;
   logic            b_win;
   logic            sel_we;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;

   // Round-robin pointer: which requester won the last grant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr <= LAST_B;
      else        ptr <= ptr_nxt;
   end

   // Grant choice, pointer advance and writeback source select
   always_comb begin
      a_win   = 1'b0;
      b_win   = 1'b0;
      ptr_nxt = ptr;
      if (reset) begin
         if (wb.a_req && wb.b_req) begin
            if (FAIR && ptr == LAST_A) b_win = 1'b1;
            else                       a_win = 1'b1;
         end else begin
            a_win = wb.a_req;
            b_win = wb.b_req;
         end
      end
      if (a_win)      ptr_nxt = LAST_A;
      else if (b_win) ptr_nxt = LAST_B;
      sel_rd   = b_win ? wb.b_rd   : wb.a_rd;
      sel_data = b_win ? wb.b_data : wb.a_data;
      // x0 grants finish the handshake but never write
      sel_we   = (a_win || b_win) && (sel_rd != 5'd0);
   end

   assign wb.a_gnt = a_win;
   assign wb.b_gnt = b_win;
   assign wb.busy  = wb.a_req & wb.b_req;

   // Register-file write port, one cycle behind the grant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb.rf_we    <= 1'b0;
         wb.rf_waddr <= 5'd0;
         wb.rf_wdata <= '0;
      end else begin
         wb.rf_we <= sel_we;
         if (a_win || b_win) begin
            wb.rf_waddr <= sel_rd;
            wb.rf_wdata <= sel_data;
         end
      end
   end

`ifdef WB_ARB_STALL_CNT_EN
   // Count denied request cycles, sticking at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_stall_cnt <= 16'd0;
         b_stall_cnt <= 16'd0;
      end else begin
         if (wb.a_req && !a_win && a_stall_cnt != 16'hFFFF)
            a_stall_cnt <= a_stall_cnt + 16'd1;
         if (wb.b_req && !b_win && b_stall_cnt != 16'hFFFF)
            b_stall_cnt <= b_stall_cnt + 16'd1;
      end
   end
`else
   // Stall counters are not built in this configuration
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a FAIR=1 and a FAIR=0 instance
// side by side, checked against a transaction-level model.
module tb_regfile_wb_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.XLEN(32)) fi ();
   regfile_wb_arbiter_if #(.XLEN(32)) xi ();

`ifdef WB_ARB_STALL_CNT_EN
   logic [15:0] f_ast, f_bst, x_ast, x_bst;
`endif

   regfile_wb_arbiter #(.FAIR(1'b1), .XLEN(32)) dut_fair (
      .clk(clk), .reset(reset), .wb(fi)
`ifdef WB_ARB_STALL_CNT_EN
      , .a_stall_cnt(f_ast), .b_stall_cnt(f_bst)
`endif
   );

   regfile_wb_arbiter #(.FAIR(1'b0), .XLEN(32)) dut_fix (
      .clk(clk), .reset(reset), .wb(xi)
`ifdef WB_ARB_STALL_CNT_EN
      , .a_stall_cnt(x_ast), .b_stall_cnt(x_bst)
`endif
   );

   // Stimulus per instance: index 0 = fair, 1 = fixed priority
   bit          ar [2];
   bit          br [2];
   logic [4:0]  ard [2];
   logic [4:0]  brd [2];
   logic [31:0] ad [2];
   logic [31:0] bd [2];

   // Model state: who was served most recently, last write seen
   bit          a_was_last [2];
   bit          m_we [2];
   logic [4:0]  m_waddr [2];
   logic [31:0] m_wdata [2];
   int          m_ast [2];
   int          m_bst [2];

   function automatic logic o_ga(int k);
      return (k == 0) ? fi.a_gnt : xi.a_gnt;
   endfunction
   function automatic logic o_gb(int k);
      return (k == 0) ? fi.b_gnt : xi.b_gnt;
   endfunction
   function automatic logic o_busy(int k);
      return (k == 0) ? fi.busy : xi.busy;
   endfunction
   function automatic logic o_we(int k);
      return (k == 0) ? fi.rf_we : xi.rf_we;
   endfunction
   function automatic logic [4:0] o_waddr(int k);
      return (k == 0) ? fi.rf_waddr : xi.rf_waddr;
   endfunction
   function automatic logic [31:0] o_wdata(int k);
      return (k == 0) ? fi.rf_wdata : xi.rf_wdata;
   endfunction

   // Who should be served: a lone requester always; on a tie
   // the fair unit serves whoever was not served last, the
   // fixed unit always serves A.
   function automatic void exp_gnt(int k, output bit ga, output bit gb);
      ga = 1'b0;
      gb = 1'b0;
      if (ar[k] && br[k]) begin
         if (k == 0 && a_was_last[k]) gb = 1'b1;
         else                         ga = 1'b1;
      end else begin
         ga = ar[k];
         gb = br[k];
      end
   endfunction

   task automatic apply();
      fi.a_req = ar[0]; fi.a_rd = ard[0]; fi.a_data = ad[0];
      fi.b_req = br[0]; fi.b_rd = brd[0]; fi.b_data = bd[0];
      xi.a_req = ar[1]; xi.a_rd = ard[1]; xi.a_data = ad[1];
      xi.b_req = br[1]; xi.b_rd = brd[1]; xi.b_data = bd[1];
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         ar[k] = 1'b0; br[k] = 1'b0;
         ard[k] = 5'd0; brd[k] = 5'd0;
         ad[k] = 32'd0; bd[k] = 32'd0;
      end
      apply();
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         a_was_last[k] = 1'b0;
         m_we[k] = 1'b0;
         m_waddr[k] = 5'd0;
         m_wdata[k] = 32'd0;
         m_ast[k] = 0;
         m_bst[k] = 0;
      end
   endtask

   task automatic model_edge();
      bit ga, gb;
      for (int k = 0; k < 2; k++) begin
         exp_gnt(k, ga, gb);
         if (ar[k] && !ga && m_ast[k] < 65535) m_ast[k]++;
         if (br[k] && !gb && m_bst[k] < 65535) m_bst[k]++;
         m_we[k] = 1'b0;
         if (ga || gb) begin
            a_was_last[k] = ga;
            m_waddr[k] = ga ? ard[k] : brd[k];
            m_wdata[k] = ga ? ad[k] : bd[k];
            m_we[k] = (m_waddr[k] != 5'd0);
         end
      end
   endtask

   // Advance one clock; callers sit just after a falling edge
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         ar[k] = 1'b1; br[k] = 1'b1;
         ard[k] = 5'd7; brd[k] = 5'd8;
         ad[k] = 32'hDEADBEEF; bd[k] = 32'hCAFEF00D;
      end
      apply();
      #3;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_ga(k) !== 1'b0 || o_gb(k) !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt k=%0d: got a=%b b=%b want 0 0",
                     k, o_ga(k), o_gb(k));
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b0 || o_waddr(k) !== 5'd0 ||
             o_wdata(k) !== 32'd0) begin
            fails++;
            $display("FAIL reset_rf k=%0d: got we=%b addr=%0d data=%h want 0",
                     k, o_we(k), o_waddr(k), o_wdata(k));
         end
      end
`ifdef WB_ARB_STALL_CNT_EN
      tests++;
      if (f_bst !== 16'd0 || x_bst !== 16'd0) begin
         fails++;
         $display("FAIL reset_cnt: got %0d %0d want 0", f_bst, x_bst);
      end
`endif
      clear_inputs();
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_tie();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         ar[k] = 1'b1; ard[k] = 5'd2; ad[k] = 32'h87654321;
         br[k] = 1'b1; brd[k] = 5'd3; bd[k] = 32'hABCDEF01;
      end
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_ga(k) !== 1'b1 || o_gb(k) !== 1'b0 || o_busy(k) !== 1'b1) begin
            fails++;
            $display("FAIL tie_c1 k=%0d: got a=%b b=%b busy=%b want 1 0 1",
                     k, o_ga(k), o_gb(k), o_busy(k));
         end
      end
      tick();
      for (int k = 0; k < 2; k++) ar[k] = 1'b0;
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b1 || o_waddr(k) !== 5'd2 ||
             o_wdata(k) !== 32'h87654321) begin
            fails++;
            $display("FAIL tie_w1 k=%0d: got we=%b addr=%0d data=%h want 1 2 87654321",
                     k, o_we(k), o_waddr(k), o_wdata(k));
         end
         tests++;
         if (o_ga(k) !== 1'b0 || o_gb(k) !== 1'b1 || o_busy(k) !== 1'b0) begin
            fails++;
            $display("FAIL tie_c2 k=%0d: got a=%b b=%b busy=%b want 0 1 0",
                     k, o_ga(k), o_gb(k), o_busy(k));
         end
      end
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b1 || o_waddr(k) !== 5'd3 ||
             o_wdata(k) !== 32'hABCDEF01) begin
            fails++;
            $display("FAIL tie_w2 k=%0d: got we=%b addr=%0d data=%h want 1 3 abcdef01",
                     k, o_we(k), o_waddr(k), o_wdata(k));
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         ar[k] = 1'b1; ard[k] = 5'd1; ad[k] = 32'h12345678;
      end
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_ga(k) !== 1'b1 || o_gb(k) !== 1'b0 || o_busy(k) !== 1'b0) begin
            fails++;
            $display("FAIL single_gnt k=%0d: got a=%b b=%b busy=%b want 1 0 0",
                     k, o_ga(k), o_gb(k), o_busy(k));
         end
      end
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b1 || o_waddr(k) !== 5'd1 ||
             o_wdata(k) !== 32'h12345678) begin
            fails++;
            $display("FAIL single_rf k=%0d: got we=%b addr=%0d data=%h want 1 1 12345678",
                     k, o_we(k), o_waddr(k), o_wdata(k));
         end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b0 || o_waddr(k) !== 5'd1 ||
             o_wdata(k) !== 32'h12345678) begin
            fails++;
            $display("FAIL idle_hold k=%0d: got we=%b addr=%0d data=%h want 0 1 12345678",
                     k, o_we(k), o_waddr(k), o_wdata(k));
         end
      end
   endtask

   task automatic test_fixed();
      do_reset();
      br[1] = 1'b1; brd[1] = 5'd20; bd[1] = 32'h0BADC0DE;
      for (int i = 0; i < 4; i++) begin
         ar[1] = 1'b1; ard[1] = 5'(4 + i); ad[1] = $urandom;
         apply();
         #1;
         tests++;
         if (xi.a_gnt !== 1'b1 || xi.b_gnt !== 1'b0 || xi.busy !== 1'b1) begin
            fails++;
            $display("FAIL fixed_gnt i=%0d: got a=%b b=%b busy=%b want 1 0 1",
                     i, xi.a_gnt, xi.b_gnt, xi.busy);
         end
         tick();
         tests++;
         if (xi.rf_we !== 1'b1 || xi.rf_waddr !== 5'(4 + i) ||
             xi.rf_wdata !== ad[1]) begin
            fails++;
            $display("FAIL fixed_rf i=%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                     i, xi.rf_we, xi.rf_waddr, xi.rf_wdata, 4 + i, ad[1]);
         end
      end
`ifdef WB_ARB_STALL_CNT_EN
      tests++;
      if (x_bst !== 16'd4 || x_ast !== 16'd0) begin
         fails++;
         $display("FAIL fixed_stall: got b=%0d a=%0d want 4 0", x_bst, x_ast);
      end
`endif
      ar[1] = 1'b0;
      apply();
      #1;
      tests++;
      if (xi.b_gnt !== 1'b1 || xi.a_gnt !== 1'b0) begin
         fails++;
         $display("FAIL fixed_release: got a=%b b=%b want 0 1",
                  xi.a_gnt, xi.b_gnt);
      end
      tick();
      clear_inputs();
      tests++;
      if (xi.rf_we !== 1'b1 || xi.rf_waddr !== 5'd20 ||
          xi.rf_wdata !== 32'h0BADC0DE) begin
         fails++;
         $display("FAIL fixed_b_rf: got we=%b addr=%0d data=%h want 1 20 0badc0de",
                  xi.rf_we, xi.rf_waddr, xi.rf_wdata);
      end
   endtask

   task automatic test_x0();
      for (int k = 0; k < 2; k++) begin
         br[k] = 1'b1; brd[k] = 5'd0; bd[k] = 32'hFFFFFFFF;
      end
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_gb(k) !== 1'b1 || o_ga(k) !== 1'b0) begin
            fails++;
            $display("FAIL x0_gnt k=%0d: got a=%b b=%b want 0 1",
                     k, o_ga(k), o_gb(k));
         end
      end
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (o_we(k) !== 1'b0) begin
            fails++;
            $display("FAIL x0_we k=%0d: got %b want 0", k, o_we(k));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d5;
      ar[0] = 1'b1; ard[0] = 5'd9; ad[0] = $urandom;
      apply();
      tick();
      d5 = $urandom;
      ar[0] = 1'b1; ard[0] = 5'd5; ad[0] = d5;
      apply();
      #1;
      tests++;
      if (fi.a_gnt !== 1'b1) begin
         fails++;
         $display("FAIL mid_gnt: got %b want 1", fi.a_gnt);
      end
      reset = 1'b0;
      #1;
      tests++;
      if (fi.a_gnt !== 1'b0 || fi.rf_we !== 1'b0 || fi.rf_waddr !== 5'd0) begin
         fails++;
         $display("FAIL mid_async: got gnt=%b we=%b addr=%0d want 0 0 0",
                  fi.a_gnt, fi.rf_we, fi.rf_waddr);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (fi.rf_we !== 1'b0 || fi.rf_waddr !== 5'd0 ||
          fi.rf_wdata !== 32'd0) begin
         fails++;
         $display("FAIL mid_drop: got we=%b addr=%0d data=%h want 0 0 0",
                  fi.rf_we, fi.rf_waddr, fi.rf_wdata);
      end
      clear_inputs();
      reset = 1'b1;
      model_reset();
      ar[0] = 1'b1; ard[0] = 5'd6; ad[0] = $urandom;
      br[0] = 1'b1; brd[0] = 5'd7; bd[0] = $urandom;
      apply();
      #1;
      tests++;
      if (fi.a_gnt !== 1'b1 || fi.b_gnt !== 1'b0) begin
         fails++;
         $display("FAIL mid_ptr: got a=%b b=%b want 1 0",
                  fi.a_gnt, fi.b_gnt);
      end
      tick();
      clear_inputs();
      tests++;
      if (fi.rf_we !== 1'b1 || fi.rf_waddr !== 5'd6) begin
         fails++;
         $display("FAIL mid_after: got we=%b addr=%0d want 1 6",
                  fi.rf_we, fi.rf_waddr);
      end
   endtask

   task automatic test_random();
      bit ga, gb;
      bit got_a [2];
      bit got_b [2];
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         got_a[k] = 1'b0;
         got_b[k] = 1'b0;
      end
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!ar[k] || got_a[k]) begin
               ar[k] = ($urandom_range(0, 2) != 0);
               ard[k] = 5'($urandom_range(0, 31));
               ad[k] = $urandom;
            end
            if (!br[k] || got_b[k]) begin
               br[k] = ($urandom_range(0, 2) != 0);
               brd[k] = 5'($urandom_range(0, 31));
               bd[k] = $urandom;
            end
         end
         apply();
         #1;
         for (int k = 0; k < 2; k++) begin
            exp_gnt(k, ga, gb);
            got_a[k] = ga;
            got_b[k] = gb;
            tests++;
            if (o_ga(k) !== ga || o_gb(k) !== gb ||
                o_busy(k) !== (ar[k] && br[k])) begin
               fails++;
               $display("FAIL rand_gnt i=%0d k=%0d: got a=%b b=%b busy=%b want %b %b %b",
                        i, k, o_ga(k), o_gb(k), o_busy(k), ga, gb, ar[k] && br[k]);
            end
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_we(k) !== m_we[k] || o_waddr(k) !== m_waddr[k] ||
                o_wdata(k) !== m_wdata[k]) begin
               fails++;
               $display("FAIL rand_rf i=%0d k=%0d: got we=%b addr=%0d data=%h want %b %0d %h",
                        i, k, o_we(k), o_waddr(k), o_wdata(k),
                        m_we[k], m_waddr[k], m_wdata[k]);
            end
         end
`ifdef WB_ARB_STALL_CNT_EN
         tests++;
         if (f_ast !== 16'(m_ast[0]) || f_bst !== 16'(m_bst[0]) ||
             x_ast !== 16'(m_ast[1]) || x_bst !== 16'(m_bst[1])) begin
            fails++;
            $display("FAIL rand_cnt i=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     i, f_ast, f_bst, x_ast, x_bst,
                     m_ast[0], m_bst[0], m_ast[1], m_bst[1]);
         end
`endif
      end
      clear_inputs();
   endtask

`ifdef WB_ARB_STALL_CNT_EN
   task automatic test_saturate();
      do_reset();
      ar[1] = 1'b1; ard[1] = 5'd11; ad[1] = 32'h5A5A5A5A;
      br[1] = 1'b1; brd[1] = 5'd12; bd[1] = 32'hA5A5A5A5;
      apply();
      repeat (65540) tick();
      tests++;
      if (x_bst !== 16'hFFFF || m_bst[1] != 65535) begin
         fails++;
         $display("FAIL saturate: got %h want ffff", x_bst);
      end
      tests++;
      if (x_ast !== 16'd0) begin
         fails++;
         $display("FAIL saturate_a: got %0d want 0", x_ast);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_tie();
      test_single();
      test_fixed();
      test_x0();
      test_reset_mid();
      test_random();
`ifdef WB_ARB_STALL_CNT_EN
      test_saturate();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
